// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Access size encoding and the per-size byte-enable mask live here.
package dmem_responder_pkg;

    localparam int unsigned LANE_W = 2;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        RSVD = 2'd3
    } mem_size_t;

    // Byte-enable for a store of the given size starting at byte lane 'lane'.
    function automatic logic [BE_W-1:0] be_mask(input mem_size_t size, input logic [LANE_W-1:0] lane);
        logic [BE_W-1:0] be;
        case (size)
            BYTE:    be = BE_W'(4'b0001 << lane);
            HALF:    be = BE_W'(4'b0011 << lane);
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: one port, synchronous byte-enabled write, combinational read.
module dmem_array #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for core load/store requests with WAIT_STATES response latency.
// Define DMEM_MISALIGN_ERR_EN to report misaligned/reserved-size accesses via rsp_err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_ADDRESS_WIDTH = 6,
    parameter int unsigned CPU_DATA_WIDTH     = 32,
    parameter int unsigned WAIT_STATES        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [DATA_ADDRESS_WIDTH+1:0] req_addr,
    input  logic [1:0]                    req_size,
    input  logic                          req_unsigned,
    input  logic [CPU_DATA_WIDTH-1:0]     req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [CPU_DATA_WIDTH-1:0]     rsp_rdata,
    output logic                          rsp_err
);

    localparam int unsigned AW    = DATA_ADDRESS_WIDTH;
    localparam int unsigned BAW   = DATA_ADDRESS_WIDTH + 2;
    localparam int unsigned DW    = CPU_DATA_WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             write_q;
    logic [BAW-1:0]   addr_q;
    mem_size_t        size_q;
    logic             unsigned_q;
    logic [DW-1:0]    wdata_q;

    logic             rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept_c;
    logic             enter_resp_c;
    logic             acc_write_c;
    logic [BAW-1:0]   acc_addr_c;
    mem_size_t        acc_size_c;
    logic             acc_unsigned_c;
    logic [DW-1:0]    acc_wdata_c;

    mem_size_t        size_c;
    logic [LANE_W-1:0] lane_c;
    logic             err_c;
    logic [DW-1:0]    rd_word_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [DW-1:0]    load_c;
    logic [DW-1:0]    wr_word_c;
    logic [BE_W-1:0]  be_c;
    logic             we_c;

    assign req_ready = (state_q == IDLE) && rst;
    assign accept_c  = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With zero wait states the access happens on the accept edge, before the latch is valid.
    assign acc_write_c    = (state_q == IDLE) ? req_write               : write_q;
    assign acc_addr_c     = (state_q == IDLE) ? req_addr                : addr_q;
    assign acc_size_c     = (state_q == IDLE) ? mem_size_t'(req_size)   : size_q;
    assign acc_unsigned_c = (state_q == IDLE) ? req_unsigned            : unsigned_q;
    assign acc_wdata_c    = (state_q == IDLE) ? req_wdata               : wdata_q;

    // State register and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request fields are captured on accept so the core is free to change them.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            write_q    <= req_write;
            addr_q     <= req_addr;
            size_q     <= mem_size_t'(req_size);
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp_c = (state_d == RESP) && (state_q != RESP);

    // Size/lane normalisation and error detection.
    always_comb begin
        size_c = acc_size_c;
        lane_c = acc_addr_c[LANE_W-1:0];
        err_c  = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        err_c = ((acc_size_c == HALF) && lane_c[0])
             || ((acc_size_c == WORD) && (lane_c != '0))
             || (acc_size_c == RSVD);
`else
        if (size_c == RSVD) begin
            size_c = WORD;
        end
        if (size_c == HALF) begin
            lane_c[0] = 1'b0;
        end
        if (size_c == WORD) begin
            lane_c = '0;
        end
`endif
    end

    // Load lane steering and extension.
    always_comb begin
        byte_c = 8'(rd_word_c >> {lane_c, 3'b000});
        half_c = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        case (size_c)
            BYTE:    load_c = {{(DW-8){!acc_unsigned_c && byte_c[7]}}, byte_c};
            HALF:    load_c = {{(DW-16){!acc_unsigned_c && half_c[15]}}, half_c};
            default: load_c = rd_word_c;
        endcase
    end

    // Store data replication and byte enables.
    always_comb begin
        case (size_c)
            BYTE:    wr_word_c = {(DW/8){acc_wdata_c[7:0]}};
            HALF:    wr_word_c = {(DW/16){acc_wdata_c[15:0]}};
            default: wr_word_c = acc_wdata_c;
        endcase
        be_c = be_mask(size_c, lane_c);
    end

    // Output logic: array commit and response capture on the edge entering RESP.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_c        = 1'b0;
        if (enter_resp_c) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (acc_write_c || err_c) ? '0 : load_c;
            rsp_err_d   = err_c;
            we_c        = rst && acc_write_c && !err_c;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    dmem_array #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) u_array (
        .clk     (clk),
        .we_i    (we_c),
        .be_i    (be_c),
        .addr_i  (acc_addr_c[BAW-1:LANE_W]),
        .wdata_i (wr_word_c),
        .rdata_o (rd_word_c)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_STATES=1, 0 and 3 instances side by side.
module tb_dmem_responder;

    localparam int unsigned AW   = 6;
    localparam int unsigned BAW  = AW + 2;
    localparam int          NDUT = 3;
    localparam int          NV   = 24;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst          [NDUT];
    logic           req_valid    [NDUT];
    logic           req_ready    [NDUT];
    logic           req_write    [NDUT];
    logic [BAW-1:0] req_addr     [NDUT];
    logic [1:0]     req_size     [NDUT];
    logic           req_unsigned [NDUT];
    logic [31:0]    req_wdata    [NDUT];
    logic           rsp_valid    [NDUT];
    logic           rsp_ready    [NDUT];
    logic [31:0]    rsp_rdata    [NDUT];
    logic           rsp_err      [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=0, instance 2: WAIT_STATES=3.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        dmem_responder #(
            .DATA_ADDRESS_WIDTH (AW),
            .CPU_DATA_WIDTH     (32),
            .WAIT_STATES        (WS)
        ) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_write    (req_write[g]),
            .req_addr     (req_addr[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full transaction; returns data, error and edges from accept to rsp_valid.
    task automatic do_req(input int d, input logic wr, input logic [7:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_write[d]    = wr;
        req_addr[d]     = addr;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_wdata[d]    = wdata;
        req_valid[d]    = 1'b1;
        rsp_ready[d]    = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid[d]    = 1'b0;
        req_wdata[d]    = $urandom;
        req_addr[d]     = addr ^ 8'h04;
        req_unsigned[d] = ~uns;
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt [NV];
        logic [31:0] rd;
        logic        er;
        int          lat;

        vt[0]  = '{1'b1, 8'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[1]  = '{1'b0, 8'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 8'h13, 2'd0, 1'b0, 32'h12345680, 32'h00000000, 1'b0};
        vt[3]  = '{1'b0, 8'h10, 2'd2, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0};
        vt[4]  = '{1'b0, 8'h13, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
        vt[5]  = '{1'b0, 8'h13, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0};
        vt[6]  = '{1'b0, 8'h12, 2'd1, 1'b0, 32'h0,        32'hFFFF80AD, 1'b0};
        vt[7]  = '{1'b0, 8'h12, 2'd1, 1'b1, 32'h0,        32'h000080AD, 1'b0};
        vt[8]  = '{1'b0, 8'h10, 2'd0, 1'b0, 32'h0,        32'hFFFFFFEF, 1'b0};
        vt[9]  = '{1'b0, 8'h10, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0};
        vt[10] = '{1'b1, 8'h20, 2'd2, 1'b0, 32'h11223344, 32'h00000000, 1'b0};
        vt[11] = '{1'b1, 8'h22, 2'd1, 1'b0, 32'hAAAA5678, 32'h00000000, 1'b0};
        vt[12] = '{1'b0, 8'h20, 2'd2, 1'b0, 32'h0,        32'h56783344, 1'b0};
        vt[13] = '{1'b0, 8'h22, 2'd1, 1'b1, 32'h0,        32'h00005678, 1'b0};
        vt[14] = '{1'b0, 8'h11, 2'd1, 1'b0, 32'h0,        ERR_EN ? 32'h0 : 32'hFFFFBEEF, ERR_EN};
        vt[15] = '{1'b1, 8'h21, 2'd2, 1'b0, 32'hCAFEF00D, 32'h00000000, ERR_EN};
        vt[16] = '{1'b0, 8'h20, 2'd2, 1'b0, 32'h0,        ERR_EN ? 32'h56783344 : 32'hCAFEF00D, 1'b0};
        vt[17] = '{1'b0, 8'h10, 2'd3, 1'b0, 32'h0,        ERR_EN ? 32'h0 : 32'h80ADBEEF, ERR_EN};
        vt[18] = '{1'b1, 8'hFC, 2'd2, 1'b0, 32'h01020304, 32'h00000000, 1'b0};
        vt[19] = '{1'b1, 8'hFF, 2'd0, 1'b0, 32'h0000005A, 32'h00000000, 1'b0};
        vt[20] = '{1'b0, 8'hFC, 2'd2, 1'b0, 32'h0,        32'h5A020304, 1'b0};
        vt[21] = '{1'b0, 8'hFF, 2'd0, 1'b1, 32'h0,        32'h0000005A, 1'b0};
        vt[22] = '{1'b0, 8'hFE, 2'd0, 1'b0, 32'h0,        32'h00000002, 1'b0};
        vt[23] = '{1'b0, 8'h10, 2'd2, 1'b1, 32'h0,        32'h80ADBEEF, 1'b0};

        for (int d = 0; d < NDUT; d++) begin
            rst[d]          = 1'b0;
            req_valid[d]    = 1'b1;
            req_write[d]    = 1'b0;
            req_addr[d]     = '0;
            req_size[d]     = 2'd2;
            req_unsigned[d] = 1'b0;
            req_wdata[d]    = '0;
            rsp_ready[d]    = 1'b1;
        end

        // Reset held for three cycles with a request pending.
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("reset dut%0d req_ready", d), 32'(req_ready[d]), 32'd0);
                check($sformatf("reset dut%0d rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            end
            check("reset rsp_rdata", rsp_rdata[0], 32'h0);
            check("reset rsp_err", 32'(rsp_err[0]), 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("post-reset req_ready", 32'(req_ready[0]), 32'd1);
        check("post-reset rsp_valid", 32'(rsp_valid[0]), 32'd0);

        // Table-driven accesses on the WAIT_STATES=1 instance.
        for (int i = 0; i < NV; i++) begin
            do_req(0, vt[i].wr, vt[i].addr, vt[i].size, vt[i].uns, vt[i].wdata, rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
        end

        // Backpressure: response held for five cycles, then one handshake.
        @(negedge clk);
        req_write[0] = 1'b0; req_addr[0] = 8'h10; req_size[0] = 2'd2;
        req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        lat = 0;
        while (!rsp_valid[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp rsp_rdata", rsp_rdata[0], 32'h80ADBEEF);
            check("bp rsp_err", 32'(rsp_err[0]), 32'd0);
            check("bp req_ready", 32'(req_ready[0]), 32'd0);
        end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp release rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("bp release req_ready", 32'(req_ready[0]), 32'd1);

        // Zero wait states: response on the cycle after accept.
        do_req(1, 1'b1, 8'h04, 2'd2, 1'b0, 32'h13572468, rd, er, lat);
        check("ws0 store latency", 32'(lat), 32'd0);
        check("ws0 store rdata", rd, 32'h0);
        do_req(1, 1'b0, 8'h04, 2'd2, 1'b0, 32'h0, rd, er, lat);
        check("ws0 load latency", 32'(lat), 32'd0);
        check("ws0 load rdata", rd, 32'h13572468);
        do_req(1, 1'b0, 8'h05, 2'd0, 1'b0, 32'h0, rd, er, lat);
        check("ws0 byte load rdata", rd, 32'h00000024);

        // Three wait states; a store interrupted by reset in WAIT must not land.
        do_req(2, 1'b1, 8'h08, 2'd2, 1'b0, 32'hA5A5A5A5, rd, er, lat);
        check("ws3 store latency", 32'(lat), 32'd3);
        @(negedge clk);
        check("ws3 ready before store", 32'(req_ready[2]), 32'd1);
        req_write[2] = 1'b1; req_addr[2] = 8'h08; req_size[2] = 2'd2;
        req_wdata[2] = 32'h0F0F0F0F; req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        check("ws3 in WAIT req_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        @(posedge clk);
        #1;
        check("ws3 reset rsp_valid", 32'(rsp_valid[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("ws3 dropped rsp_valid", 32'(rsp_valid[2]), 32'd0);
        end
        do_req(2, 1'b0, 8'h08, 2'd2, 1'b0, 32'h0, rd, er, lat);
        check("ws3 storage unchanged", rd, 32'hA5A5A5A5);
        check("ws3 load latency", 32'(lat), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
